// File: rtl/rom_arb_pkg.sv
// Shared defaults, ROM image and FSM state type for the two-requester ROM arbiter.
// Optional feature macro used by rom_arbiter: ROM_ARB_ROUND_ROBIN_EN.
package rom_arb_pkg;

    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 4;

    localparam int ROM_DEPTH  = 4;
    localparam int ROM_WORD_W = 4;

    // Word 0 sits in the least-significant nibble.
    localparam logic [ROM_DEPTH*ROM_WORD_W-1:0] ROM_CONTENTS = {
        4'b1100,
        4'b0011,
        4'b0101,
        4'b1010
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Addresses beyond the populated image read as zero.
    function automatic logic [ROM_WORD_W-1:0] rom_word(input logic [31:0] idx);
        if (idx < 32'(ROM_DEPTH)) begin
            return ROM_CONTENTS[idx*ROM_WORD_W +: ROM_WORD_W];
        end
        return '0;
    endfunction

endpackage

// File: rtl/rom_sync.sv
// Synchronous ROM: the word for i_addr appears on o_data one cycle after i_en.
// The output register holds its value while i_en is low.
module rom_sync
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_word;

    assign w_word = DATA_W'(rom_word(32'(i_addr)));

    // NOTE: the contents are a constant, so only the read register is reset; it costs nothing and keeps o_data defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_word;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of a synchronous ROM, one transaction in flight.
// Define ROM_ARB_ROUND_ROBIN_EN to alternate ties; otherwise requester 0 wins ties.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    input  logic [2*ADDR_W-1:0] req_addr,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [2*DATA_W-1:0] rsp_data,
    input  logic [1:0]          rsp_ready,
    output logic                busy,
    output logic [7:0]          txn_count
);

    state_t            r_state;
    logic              r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_txn_count;
`ifdef ROM_ARB_ROUND_ROBIN_EN
    logic              r_last_grant;
`endif

    logic              w_grant_idx;
    logic              w_req_fire;
    logic              w_rsp_fire;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [DATA_W-1:0] w_rom_data;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_grant_idx = 1'b0;
        if (req_valid == 2'b10) begin
            w_grant_idx = 1'b1;
        end
`ifdef ROM_ARB_ROUND_ROBIN_EN
        else if (req_valid == 2'b11) begin
            w_grant_idx = ~r_last_grant;
        end
`endif
    end

    // Ready goes only to the winner, so any ready in IDLE is also the handshake.
    assign w_req_fire   = !rst && (r_state == ST_IDLE) && (req_valid != 2'b00);
    assign req_ready    = w_req_fire ? (2'b01 << w_grant_idx) : 2'b00;
    assign w_grant_addr = w_grant_idx ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
    assign w_rsp_fire   = (r_state == ST_RESP) && rsp_ready[r_owner];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_addr      <= '0;
            r_txn_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_fire) begin
                        r_owner <= w_grant_idx;
                        r_addr  <= w_grant_addr;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_fire) begin
                        r_state     <= ST_IDLE;
                        r_txn_count <= r_txn_count + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ROM_ARB_ROUND_ROBIN_EN
    // Resetting to 1 makes requester 0 the first tie winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_rsp_fire) begin
            r_last_grant <= r_owner;
        end
    end
`endif

    rom_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state == ST_READ),
        .i_addr (r_addr),
        .o_data (w_rom_data)
    );

    always_comb begin
        rsp_valid = 2'b00;
        rsp_data  = '0;
        if (r_state == ST_RESP) begin
            if (r_owner) begin
                rsp_valid[1]               = 1'b1;
                rsp_data[DATA_W +: DATA_W] = w_rom_data;
            end else begin
                rsp_valid[0]          = 1'b1;
                rsp_data[0 +: DATA_W] = w_rom_data;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios plus random transactions
// checked against a transaction-level model (winner rule, ROM table, counter).
module tb_rom_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [3:0] req_addr;
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic [7:0] rsp_data;
    logic [1:0] rsp_ready;
    logic       busy;
    logic [7:0] txn_count;

    int checks = 0;
    int errors = 0;

    int m_last_grant = 1;
    int m_count      = 0;
    logic [3:0] rom_model [4] = '{4'b1010, 4'b0101, 4'b0011, 4'b1100};

    rom_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_winner(input logic [1:0] v);
        if (v == 2'b10) return 1;
        if (v == 2'b11) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
            return 1 - m_last_grant;
`else
            return 0;
`endif
        end
        return 0;
    endfunction

    task automatic model_complete(input int w);
        m_last_grant = w;
        m_count      = (m_count + 1) % 256;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst          = 1'b0;
        m_count      = 0;
        m_last_grant = 1;
    endtask

    // One full transaction starting from IDLE; owner withholds rsp_ready for 'hold' RESP cycles.
    task automatic run_txn(input logic [1:0] v, input logic [1:0] a0, input logic [1:0] a1, input int hold);
        int         w;
        logic [3:0] exp_d;
        logic [7:0] exp_pk;
        @(negedge clk);
        req_valid = v;
        req_addr  = {a1, a0};
        rsp_ready = 2'b00;
        w         = model_winner(v);
        exp_d     = rom_model[(w == 0) ? a0 : a1];
        exp_pk    = 8'(exp_d) << (4 * w);
        #1;
        check("idle_req_ready", 32'(req_ready), 32'(1) << w);
        check("idle_busy", 32'(busy), 0);
        check("idle_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        req_valid = 2'($urandom_range(0, 3));
        req_addr  = 4'($urandom);
        #1;
        check("read_req_ready", 32'(req_ready), 0);
        check("read_rsp_valid", 32'(rsp_valid), 0);
        check("read_busy", 32'(busy), 1);
        for (int i = 0; i <= hold; i++) begin
            @(negedge clk);
            req_valid    = 2'($urandom_range(0, 3));
            rsp_ready    = 2'($urandom_range(0, 3));
            rsp_ready[w] = (i == hold);
            #1;
            check("resp_valid", 32'(rsp_valid), 32'(1) << w);
            check("resp_data", 32'(rsp_data), 32'(exp_pk));
            check("resp_req_ready", 32'(req_ready), 0);
            check("resp_busy", 32'(busy), 1);
        end
        @(negedge clk);
        model_complete(w);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        #1;
        check("done_count", 32'(txn_count), 32'(m_count));
        check("done_busy", 32'(busy), 0);
        check("done_rsp_valid", 32'(rsp_valid), 0);
    endtask

    initial begin
        int w;

        // Outputs while reset is held, with both requesters asserting.
        rst       = 1'b1;
        req_valid = 2'b11;
        req_addr  = 4'b1100;
        rsp_ready = 2'b11;
        @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_txn_count", 32'(txn_count), 0);
        do_reset();

        // Single requester 0 reading address 2, then requester 1 stalling its response.
        run_txn(2'b01, 2'd2, 2'd0, 0);
        check("first_count", 32'(txn_count), 1);
        run_txn(2'b10, 2'd0, 2'd1, 5);

        // Both requesters valid continuously with responses always accepted.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_valid = 2'b11;
            req_addr  = {2'd3, 2'd0};
            rsp_ready = 2'b11;
            w = model_winner(2'b11);
            #1;
            check("tie_grant", 32'(req_ready), 32'(1) << w);
            @(negedge clk);
            #1;
            check("tie_read_busy", 32'(busy), 1);
            check("tie_read_ready", 32'(req_ready), 0);
            @(negedge clk);
            #1;
            check("tie_rsp_valid", 32'(rsp_valid), 32'(1) << w);
            check("tie_rsp_data", 32'(rsp_data), (w == 0) ? 32'h0A : 32'hC0);
            model_complete(w);
        end
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        #1;
        check("tie_count", 32'(txn_count), 32'(m_count));

        // Reset asserted while in READ abandons the transaction.
        @(negedge clk);
        req_valid = 2'b01;
        req_addr  = 4'b0001;
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        check("pre_rst_busy", 32'(busy), 1);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 32'(req_ready), 0);
        check("midrst_rsp_valid", 32'(rsp_valid), 0);
        check("midrst_rsp_data", 32'(rsp_data), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_count", 32'(txn_count), 0);
        @(negedge clk);
        rst          = 1'b0;
        req_valid    = 2'b00;
        rsp_ready    = 2'b11;
        m_count      = 0;
        m_last_grant = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("post_rst_rsp_valid", 32'(rsp_valid), 0);
            check("post_rst_busy", 32'(busy), 0);
            check("post_rst_count", 32'(txn_count), 0);
        end

        // Random traffic; exactly 256 completions after reset must wrap the counter.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            run_txn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end
        check("wrap_count", 32'(txn_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 2, ROM address width per requester.
REQ-002 Parameter DATA_W, default 4, ROM word width.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port req_valid  input  2  per-requester read request; bit i = requester i.
REQ-006 Port req_addr  input  2*ADDR_W  packed addresses; slice [i*ADDR_W +: ADDR_W] = requester i.
REQ-007 Port req_ready  output  2  request accepted when req_valid[i]&req_ready[i].
REQ-008 Port rsp_valid  output  2  read data valid for requester i.
REQ-009 Port rsp_data  output  2*DATA_W  packed read data, same slicing as req_addr.
REQ-010 Port rsp_ready  input  2  requester i consumes the response when rsp_valid[i]&rsp_ready[i].
REQ-011 Port busy  output  1  high in any state other than IDLE.
REQ-012 Port txn_count  output  8  count of completed responses.

Function
REQ-013 The FSM SHALL have states IDLE, READ, RESP; only one transaction is outstanding at a time.
REQ-014 In IDLE, req_ready SHALL be high only for the arbitration winner among asserted req_valid bits, combinationally; all bits SHALL be low in READ and RESP.
REQ-015 On handshake in IDLE, the block SHALL latch the address and owner index and go to READ next cycle.
REQ-016 READ SHALL last exactly one cycle, presenting the latched address to the synchronous ROM, then go to RESP.
REQ-017 In RESP, rsp_valid[owner] SHALL be high and rsp_data[owner] SHALL hold the ROM word, stable until rsp_ready[owner]; the non-owner slice and valid SHALL be 0.
REQ-018 Latency: handshake at edge N yields rsp_valid at cycle N+2; minimum 3 cycles per transaction.
REQ-019 On the response handshake the FSM SHALL return to IDLE, txn_count SHALL increment (wrapping 255->0) and last_grant SHALL update to owner; no new request is accepted in that same cycle.
REQ-020 ROM contents SHALL be: addr 0 -> 4'b1010, 1 -> 4'b0101, 2 -> 4'b0011, 3 -> 4'b1100.
REQ-021 Deasserting req_valid after handshake SHALL have no effect on the transaction in flight.

Reset
REQ-022 While rst is high: state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, busy=0, txn_count=0, last_grant=1 (requester 0 wins first tie).
REQ-023 Reset mid-transaction SHALL abandon it with no response delivered and no count increment.

Configuration
REQ-024 With ROM_ARB_ROUND_ROBIN_EN defined, ties SHALL go to the requester other than last_grant; without it, requester 0 SHALL always win ties and last_grant is unused.

Structure
REQ-025 Package rom_arb_pkg SHALL hold ADDR_W/DATA_W defaults, the ROM contents constant, and the FSM state enum.
REQ-026 The ROM SHALL be a sub-module rom_sync (registered read, one-cycle latency) instantiated once.

Verification
REQ-027 Reset release, req_valid=01, addr0=2 -> ready[0] same cycle, rsp_valid[0] two cycles later with data 4'b0011, txn_count=1 after consume.
REQ-028 Both valid every cycle, addr0=0, addr1=3, rsp_ready=11, round-robin -> grants alternate 0,1,0,1; data 1010/1100; 3-cycle spacing.
REQ-029 Same as REQ-028 without ROM_ARB_ROUND_ROBIN_EN -> requester 0 granted every time; requester 1 never granted.
REQ-030 rsp_ready[1] held low 5 cycles in RESP -> rsp_valid[1] and data 4'b0101 stable; req_ready stays 00; busy=1.
REQ-031 rst pulsed in READ -> all outputs 0 immediately, no rsp_valid, txn_count=0.
REQ-032 256 completed transactions -> txn_count wraps to 0.
